// File: rtl/switch_input_responder.sv
// Debounced confirm button that captures the 16 DIP switches into a memory-mapped
// register window (DATA, STATUS, LIVE) read by the CPU over a simple IO strobe.
module switch_input_responder #(
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switchInput,
  input  logic        confirmation,
  input  logic        ioRead,
  input  logic [31:0] address,
  output logic [15:0] dataIOInput,
  output logic        pending
);

  localparam int          CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DATA_ADDR   = BASE_ADDR;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] LIVE_ADDR   = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic        btn_meta;
  logic        btn_sync;

  deb_state_t  state;
  logic [CW-1:0] count;
  logic        capture_fire;

  logic [15:0] capture_data;
  logic        overrun;
  logic        data_read;

  // Two-flop synchronizers; everything downstream sees only the synced copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= switchInput;
      sw_sync  <= sw_meta;
      btn_meta <= confirmation;
      btn_sync <= btn_meta;
    end
  end

  // The event fires on the edge where the press count reaches the threshold,
  // so the capture and the move to HELD land on the same edge.
  always_comb begin
    capture_fire = 1'b0;
    if (btn_sync) begin
      if (state == PRESS_WAIT && count == DEB_LAST)
        capture_fire = 1'b1;
      else if (state == IDLE && DEBOUNCE_CYCLES <= 1)
        capture_fire = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_sync) begin
            if (capture_fire) begin
              state <= HELD;
              count <= '0;
            end else begin
              state <= PRESS_WAIT;
              count <= CW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
            count <= '0;
          end else if (capture_fire) begin
            state <= HELD;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        HELD: begin
          if (!btn_sync) begin
            if (DEBOUNCE_CYCLES <= 1) begin
              state <= IDLE;
              count <= '0;
            end else begin
              state <= RELEASE_WAIT;
              count <= CW'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            state <= HELD;
            count <= '0;
          end else if (count == DEB_LAST) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign data_read = ioRead && !rst && (address == DATA_ADDR);

  // A capture on the same edge as a DATA read wins: the read consumed the old
  // value, so the new one is pending but nothing was lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      capture_data <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
    end else if (capture_fire) begin
      capture_data <= sw_sync;
      pending      <= 1'b1;
      overrun      <= pending && !data_read;
    end else if (data_read) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end
  end

  always_comb begin
    dataIOInput = 16'h0000;
    if (ioRead && !rst) begin
      if (address == DATA_ADDR)
        dataIOInput = capture_data;
      else if (address == STATUS_ADDR)
        dataIOInput = {14'b0, overrun, pending};
      else if (address == LIVE_ADDR)
        dataIOInput = sw_sync;
    end
  end

endmodule
